// File: rtl/seg_cmd_driver.sv
// Host-side command driver for the seven-segment register/ALU tile: queues 12-bit
// commands, strobes them onto the tile bus, waits a settle time, decodes the display.
module seg_cmd_driver #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETTLE     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [11:0] cmd_data,
    output logic [3:0]  out_data,
    output logic [3:0]  out_addr,
    output logic [3:0]  out_opcode,
    output logic        out_write_enable,
    input  logic [6:0]  seg_in,
    output logic        rsp_valid,
    output logic [3:0]  rsp_nibble,
    output logic        rsp_error,
    output logic        busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;

    logic [11:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [11:0] head;

    // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign busy      = (state != S_IDLE) || !empty;

    always_comb begin
        pop = 1'b0;
        if (!empty && (state == S_IDLE || state == S_RESP))
            pop = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= cmd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h77:   decode = 5'h0A;
            7'h7C:   decode = 5'h0B;
            7'h39:   decode = 5'h0C;
            7'h5E:   decode = 5'h0D;
            7'h79:   decode = 5'h0E;
            7'h71:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    // The bus is loaded on the edge entering DRIVE so the strobe and its data coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            out_data         <= '0;
            out_addr         <= '0;
            out_opcode       <= '0;
            out_write_enable <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_nibble       <= '0;
            rsp_error        <= 1'b0;
        end else begin
            out_write_enable <= 1'b0;
            rsp_valid        <= 1'b0;
            case (state)
                S_IDLE, S_RESP: begin
                    if (pop) begin
                        {out_opcode, out_addr, out_data} <= head;
                        out_write_enable <= 1'b1;
                        state            <= S_DRIVE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    cnt   <= SETTLE_LAST;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        {rsp_error, rsp_nibble} <= decode(seg_in);
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_cmd_driver.sv
// Directed bench for seg_cmd_driver: table of single commands plus burst, reset and wrap sequences.
module tb_seg_cmd_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_data;
    logic [3:0]  out_data;
    logic [3:0]  out_addr;
    logic [3:0]  out_opcode;
    logic        out_write_enable;
    logic [6:0]  seg_in;
    logic        rsp_valid;
    logic [3:0]  rsp_nibble;
    logic        rsp_error;
    logic        busy;

    seg_cmd_driver #(.FIFO_DEPTH(4), .SETTLE(3)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .out_data(out_data), .out_addr(out_addr),
        .out_opcode(out_opcode), .out_write_enable(out_write_enable),
        .seg_in(seg_in), .rsp_valid(rsp_valid), .rsp_nibble(rsp_nibble),
        .rsp_error(rsp_error), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] cmd;
        logic [6:0]  seg;
        logic [3:0]  nib;
        logic        err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] glyph [16];
    vec_t vecs [22];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Push one command into an idle block and follow it through to its response.
    task automatic run_one(input vec_t v);
        cmd_valid = 1'b1;
        cmd_data  = v.cmd;
        seg_in    = v.seg;
        chk("one_ready", 32'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("one_we", 32'(out_write_enable), 32'(c == 1));
            chk("one_rsp_valid", 32'(rsp_valid), 32'(c == 5));
            if (c == 1 || c == 5)
                chk("one_bus", 32'({out_opcode, out_addr, out_data}), 32'(v.cmd));
            if (c == 5) begin
                chk("one_nibble", 32'(rsp_nibble), 32'(v.nib));
                chk("one_error", 32'(rsp_error), 32'(v.err));
            end
        end
        step();
        chk("one_idle_busy", 32'(busy), 0);
    endtask

    function automatic logic [11:0] mk(input int i);
        logic [3:0] op;
        logic [3:0] ad;
        logic [3:0] dt;
        op = 4'(i) ^ 4'h5;
        ad = 4'(i * 3);
        dt = 4'(i * 7 + 3);
        return {op, ad, dt};
    endfunction

    initial begin
        logic [11:0] burst [5];
        logic [11:0] strobe_q [$];
        logic [3:0]  rsp_q [$];
        logic        acc;
        logic        prev_we;
        int          pushed;
        int          nrsp;

        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 16; i++)
            vecs[i] = '{cmd: {4'(i), 4'(15 - i), 4'(i)}, seg: glyph[i], nib: 4'(i), err: 1'b0};
        vecs[16] = '{cmd: 12'h3A5, seg: 7'h6D, nib: 4'h5, err: 1'b0};
        vecs[17] = '{cmd: 12'h111, seg: 7'h00, nib: 4'h0, err: 1'b1};
        vecs[18] = '{cmd: 12'h22F, seg: 7'h71, nib: 4'hF, err: 1'b0};
        vecs[19] = '{cmd: 12'hFFF, seg: 7'h7E, nib: 4'h0, err: 1'b1};
        vecs[20] = '{cmd: 12'h8C1, seg: 7'h06, nib: 4'h1, err: 1'b0};
        vecs[21] = '{cmd: 12'h000, seg: 7'h3E, nib: 4'h0, err: 1'b1};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = '0;
        seg_in = '0;
        step();
        step();
        chk("rst_ready_low", 32'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        chk("rst_out", 32'({out_opcode, out_addr, out_data}), 0);
        chk("rst_we", 32'(out_write_enable), 0);
        chk("rst_rsp", 32'({rsp_valid, rsp_error, rsp_nibble}), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);

        for (int i = 0; i < 22; i++)
            run_one(vecs[i]);

        // Five back-to-back pushes: four queue up behind the one in flight.
        for (int i = 0; i < 5; i++)
            burst[i] = {4'(i + 1), 4'(2 * i + 3), 4'(9 - i)};
        cmd_valid = 1'b1;
        cmd_data  = burst[0];
        seg_in    = glyph[9];
        step();
        for (int c = 0; c <= 26; c++) begin
            chk("burst_we", 32'(out_write_enable), 32'((c % 5 == 1) && c <= 21));
            chk("burst_rsp_valid", 32'(rsp_valid), 32'((c % 5 == 0) && c >= 5 && c <= 25));
            if (out_write_enable && c >= 1 && c <= 21)
                chk("burst_bus", 32'({out_opcode, out_addr, out_data}), 32'(burst[(c - 1) / 5]));
            if (rsp_valid && c >= 5 && c <= 25)
                chk("burst_nibble", 32'(rsp_nibble), 32'(9 - (c / 5 - 1)));
            if (c == 4 || c == 5)
                chk("burst_full", 32'(cmd_ready), 0);
            if (c == 6)
                chk("burst_ready_again", 32'(cmd_ready), 1);
            if (c < 4) begin
                chk("burst_accept", 32'(cmd_ready), 1);
                cmd_valid = 1'b1;
                cmd_data  = burst[c + 1];
            end else begin
                cmd_valid = 1'b0;
            end
            if (c / 5 < 5)
                seg_in = glyph[9 - c / 5];
            step();
        end

        // Reset during SETTLE with two commands still queued.
        cmd_valid = 1'b1;
        cmd_data  = 12'h123;
        seg_in    = glyph[3];
        step();
        cmd_data = 12'h456;
        step();
        chk("mid_strobe", 32'(out_write_enable), 1);
        cmd_data = 12'h789;
        step();
        cmd_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_out", 32'({out_opcode, out_addr, out_data}), 0);
        chk("mid_rst_rsp", 32'({rsp_valid, rsp_error, rsp_nibble, out_write_enable}), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        chk("mid_ready", 32'(cmd_ready), 1);
        for (int c = 0; c < 12; c++) begin
            step();
            chk("mid_quiet", 32'({out_write_enable, rsp_valid, busy}), 0);
        end

        // Stream 20 commands; seg_in mirrors a tile displaying the written data nibble.
        pushed  = 0;
        nrsp    = 0;
        prev_we = 1'b0;
        for (int c = 0; c < 400 && nrsp < 20; c++) begin
            cmd_valid = (pushed < 20) && (c % 4 == 0);
            cmd_data  = mk(pushed);
            seg_in    = glyph[out_data];
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) begin
                strobe_q.push_back(mk(pushed));
                rsp_q.push_back(mk(pushed) & 12'h00F);
                pushed++;
            end
            if (out_write_enable) begin
                if (prev_we)
                    chk("wrap_double_strobe", 1, 0);
                if (strobe_q.size() == 0)
                    chk("wrap_spurious_strobe", 1, 0);
                else
                    chk("wrap_bus", 32'({out_opcode, out_addr, out_data}), 32'(strobe_q.pop_front()));
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0)
                    chk("wrap_spurious_rsp", 1, 0);
                else
                    chk("wrap_nibble", 32'({rsp_error, rsp_nibble}), 32'(rsp_q.pop_front()));
                nrsp++;
            end
            prev_we = out_write_enable;
        end
        cmd_valid = 1'b0;
        chk("wrap_rsp_count", 32'(nrsp), 20);
        chk("wrap_pushed", 32'(pushed), 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_cmd_driver.md
# seg_cmd_driver

Host-side command driver for the seven-segment register/ALU tile. It buffers 12-bit commands, drives them onto the tile's data/address/opcode/write-enable inputs with a single-cycle write strobe, and waits a fixed settle time. It then samples the tile's seven-segment output and decodes it back to a hex nibble as a response. It sits between a test/host controller and the tile's input pins and closes the loop on the display output.

## Interface
Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- SETTLE, 3, cycles the bus is held after the write strobe before sampling; ≥1

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full, forced 0 while rst=1
- cmd_data  in  12  {opcode[11:8], addr[7:4], data[3:0]}
- out_data  out  4  to tile in_data
- out_addr  out  4  to tile in_addr
- out_opcode  out  4  to tile in_opcode
- out_write_enable  out  1  to tile in_write_enable; one-cycle strobe per command
- seg_in  in  7  tile segments, active-high, bit0=a … bit6=g
- rsp_valid  out  1  one-cycle response pulse
- rsp_nibble  out  4  decoded digit
- rsp_error  out  1  seg_in pattern not a valid hex glyph
- busy  out  1  state≠IDLE or FIFO non-empty

## Operation
- Push when cmd_valid && cmd_ready. cmd_ready comes from the registered full flag, so a push into a full FIFO is never accepted, even if a pop occurs in the same cycle.
- FIFO is first-word-fall-through. Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH. Full/empty is determined by MSB compare.
- FSM states:
  - IDLE: bus holds its last values and out_write_enable=0. Leaves to DRIVE when the FIFO is non-empty. The FIFO head is popped on this transition.
  - DRIVE (1 cycle): out_opcode/out_addr/out_data are registered from the popped entry and out_write_enable=1. Next state is SETTLE.
  - SETTLE (SETTLE cycles, down-counter): out_write_enable=0 and the bus holds. On the edge leaving the last SETTLE cycle, seg_in is captured and decoded into rsp_nibble/rsp_error. Next state is RESP.
  - RESP (1 cycle): rsp_valid=1. Goes to DRIVE (popping the head) if the FIFO is non-empty, otherwise to IDLE.
- Decode table (seg_in hex → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
  - Any other pattern gives rsp_nibble=0 and rsp_error=1.
  - A valid glyph gives rsp_error=0.
- rsp_nibble and rsp_error hold their values until the next capture. rsp_valid is high only in RESP.
- A push and a pop in the same cycle are both performed; the occupancy count is unchanged.

## Timing
- Reset values:
  - out_data, out_addr, out_opcode, out_write_enable, rsp_valid, rsp_nibble, rsp_error are all 0.
  - FSM is in IDLE, FIFO is empty, busy=0.
  - cmd_ready=1 on the first cycle after rst deasserts.
- Single command into an idle, empty block, push accepted at cycle 0:
  - DRIVE (strobe) at cycle 1
  - SETTLE at cycles 2..SETTLE+1
  - RESP/rsp_valid at cycle SETTLE+2 (cycle 5 with the default SETTLE)
- Back-to-back queued commands: one command every SETTLE+2 cycles. The next strobe is in the cycle immediately after RESP.
- A pushed command is not visible to the FSM until the cycle after the push (FIFO registered).
- rst asserted in any state: the next cycle shows all reset values. Queued commands are flushed, and no rsp_valid or strobe is emitted for the interrupted command.
- out_write_enable is never high for two consecutive cycles.

## Test plan
- Reset: hold rst 2 cycles then release. All outputs are 0, cmd_ready=1, busy=0.
- Single command: push 12'h3A5, with seg_in=7'h6D throughout.
  - Cycle 1: out_opcode=3, out_addr=A, out_data=5, out_write_enable=1.
  - Cycle 5: rsp_valid=1, rsp_nibble=5, rsp_error=0.
- Back-to-back and full:
  - Push 5 commands on consecutive cycles with FIFO_DEPTH=4. The first is accepted and popped at cycle 1.
  - cmd_ready drops after 5 accepts (4 queued + 1 in flight); any further offer is held.
  - Strobes occur at cycles 1, 6, 11, 16, 21, with rsp_valid at 5, 10, 15, 20, 25.
- Invalid glyph: seg_in=7'h00 at capture gives rsp_valid=1, rsp_nibble=0, rsp_error=1. A following command with seg_in=7'h71 gives rsp_nibble=F, rsp_error=0.
- Reset mid-operation: assert rst during SETTLE with 2 commands queued. The next cycle shows all reset values. No rsp_valid or strobe appears afterwards until a new push.
- Pointer wrap: stream 20 commands with varying data while keeping the FIFO partly full. The responses match the seg_in stimulus in order, with no loss or duplication across pointer wrap.
